// File: rtl/pixel_map_pkg.sv
// Shared types and helpers for the raster coordinate streamer.
// PIXEL_MAP_SATURATE_EN widens accumulators and clamps output coordinates.
package pixel_map_pkg;

  localparam int COORD_W = 25;
  localparam int PIX_W   = 10;

`ifdef PIXEL_MAP_SATURATE_EN
  localparam int ACC_W = COORD_W + PIX_W;
`else
  localparam int ACC_W = COORD_W;
`endif

  typedef enum logic [1:0] {IDLE, SETUP1, SETUP2, RUN} state_t;
  typedef logic signed [COORD_W-1:0] coord_t;
  typedef logic signed [ACC_W-1:0]   acc_t;

  // Narrow an accumulator value to an output coordinate (clamp or wrap).
  function automatic coord_t sat_coord(input acc_t v);
`ifdef PIXEL_MAP_SATURATE_EN
    logic [ACC_W-COORD_W:0] hi;
    hi = v[ACC_W-1:COORD_W-1];
    if (hi == '0 || hi == '1) return coord_t'(v[COORD_W-1:0]);
    return v[ACC_W-1] ? coord_t'({1'b1, {(COORD_W-1){1'b0}}})
                      : coord_t'({1'b0, {(COORD_W-1){1'b1}}});
`else
    return v;
`endif
  endfunction

endpackage

// File: rtl/pixel_lane_adder.sv
// One output lane: running real-axis accumulator, reloaded at each line start.
module pixel_lane_adder
  import pixel_map_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   i_load,
  input  logic   i_adv,
  input  acc_t   i_base,
  input  acc_t   i_off,
  input  acc_t   i_step,
  output coord_t o_coord
);

  acc_t r_acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_acc <= '0;
    else if (i_load) r_acc <= i_base + i_off;
    else if (i_adv)  r_acc <= r_acc + i_step;
  end

  assign o_coord = sat_coord(r_acc);

endmodule

// File: rtl/pixel_map_stream.sv
// Self-scanning raster walker: emits N_LANES adjacent pixels and their coordinates per beat.
// Define PIXEL_MAP_SATURATE_EN to clamp output coordinates instead of wrapping.
module pixel_map_stream
  import pixel_map_pkg::*;
#(
  parameter int PIXEL_DATA_WIDTH   = PIX_W,
  parameter int ENGINE_DATA_WIDTH  = COORD_W,
  parameter int ENGINE_FRACT_WIDTH = 20,
  parameter int SCREEN_WIDTH       = 640,
  parameter int SCREEN_HEIGHT      = 480,
  parameter int N_LANES            = 1,
  parameter int BASE_STEP          = 4915
)(
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [2:0]                           zoom,
  input  logic signed [ENGINE_DATA_WIDTH-1:0]  x_offset,
  input  logic signed [ENGINE_DATA_WIDTH-1:0]  y_offset,
  input  logic                                 out_ready,
  output logic                                 out_valid,
  output logic [N_LANES*ENGINE_DATA_WIDTH-1:0] real_x,
  output logic signed [ENGINE_DATA_WIDTH-1:0]  imag_y,
  output logic [PIXEL_DATA_WIDTH-1:0]          pixel_x,
  output logic [PIXEL_DATA_WIDTH-1:0]          pixel_y,
  output logic                                 line_end,
  output logic                                 frame_end,
  output logic                                 busy
);

  if (SCREEN_WIDTH % N_LANES != 0) begin : g_bad_lanes
    $error("SCREEN_WIDTH must be a multiple of N_LANES");
  end
  if (ENGINE_DATA_WIDTH != COORD_W || ENGINE_FRACT_WIDTH >= ENGINE_DATA_WIDTH) begin : g_bad_fmt
    $error("coordinate format does not match pixel_map_pkg");
  end

  localparam acc_t HALF_W = acc_t'(SCREEN_WIDTH / 2);
  localparam acc_t HALF_H = acc_t'(SCREEN_HEIGHT / 2);
  localparam acc_t LANES  = acc_t'(N_LANES);
  localparam logic [PIXEL_DATA_WIDTH-1:0] LAST_X = PIXEL_DATA_WIDTH'(SCREEN_WIDTH - N_LANES);
  localparam logic [PIXEL_DATA_WIDTH-1:0] LAST_Y = PIXEL_DATA_WIDTH'(SCREEN_HEIGHT - 1);

  state_t r_state, w_state_nxt;

  logic [2:0] r_zoom;
  coord_t     r_xoff, r_yoff;
  acc_t       r_step, r_x_start, r_beat_step, r_imag_acc;
  acc_t       r_lane_off [N_LANES];
  logic [PIXEL_DATA_WIDTH-1:0] r_px, r_py;

  acc_t w_step, w_x_start, w_y_start;
  acc_t w_lane_off [N_LANES];
  logic w_fire, w_last_x, w_last_y, w_setup, w_load, w_adv;

  assign w_step    = acc_t'(BASE_STEP) >>> r_zoom;
  assign w_x_start = acc_t'(r_xoff) - HALF_W * r_step;
  assign w_y_start = acc_t'(r_yoff) - HALF_H * r_step;

  assign out_valid = (r_state == RUN);
  assign busy      = (r_state != IDLE);
  assign w_fire    = out_valid && out_ready;
  assign w_last_x  = (r_px == LAST_X);
  assign w_last_y  = (r_py == LAST_Y);
  assign w_setup   = (r_state == SETUP2);
  // Lanes reload from x_start at frame setup and after every line's last beat.
  assign w_load    = w_setup || (w_fire && w_last_x);
  assign w_adv     = w_fire && !w_last_x;

  assign line_end  = out_valid && w_last_x;
  assign frame_end = line_end && w_last_y;
  assign pixel_x   = r_px;
  assign pixel_y   = r_py;
  assign imag_y    = sat_coord(r_imag_acc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = SETUP1;
      SETUP1:  w_state_nxt = SETUP2;
      SETUP2:  w_state_nxt = RUN;
      RUN:     if (w_fire && w_last_x && w_last_y) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_zoom      <= '0;
      r_xoff      <= '0;
      r_yoff      <= '0;
      r_step      <= '0;
      r_x_start   <= '0;
      r_beat_step <= '0;
      r_imag_acc  <= '0;
      r_px        <= '0;
      r_py        <= '0;
      for (int i = 0; i < N_LANES; i++) r_lane_off[i] <= '0;
    end else begin
      if (r_state == IDLE && start) begin
        r_zoom <= zoom;
        r_xoff <= x_offset;
        r_yoff <= y_offset;
      end
      if (r_state == SETUP1) r_step <= w_step;
      if (w_setup) begin
        r_x_start   <= w_x_start;
        r_beat_step <= LANES * r_step;
        r_imag_acc  <= w_y_start;
        r_px        <= '0;
        r_py        <= '0;
        for (int i = 0; i < N_LANES; i++) r_lane_off[i] <= w_lane_off[i];
      end else if (w_fire) begin
        if (w_last_x) begin
          r_px       <= '0;
          r_py       <= r_py + 1'b1;
          r_imag_acc <= r_imag_acc + r_step;
        end else begin
          r_px <= r_px + PIXEL_DATA_WIDTH'(N_LANES);
        end
      end
    end
  end

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    localparam acc_t LANE_K = acc_t'(k);
    coord_t w_coord;

    assign w_lane_off[k] = LANE_K * r_step;

    pixel_lane_adder u_lane (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_load),
      .i_adv   (w_adv),
      .i_base  (w_setup ? w_x_start : r_x_start),
      .i_off   (w_setup ? w_lane_off[k] : r_lane_off[k]),
      .i_step  (r_beat_step),
      .o_coord (w_coord)
    );

    assign real_x[k*ENGINE_DATA_WIDTH +: ENGINE_DATA_WIDTH] = w_coord;
  end

endmodule

// File: tb/tb_pixel_map_stream.sv
// Directed bench for pixel_map_stream: 2 lanes, 640x4 screen to keep frames short.
module tb_pixel_map_stream;

  localparam int W   = 25;
  localparam int PW  = 10;
  localparam int SW  = 640;
  localparam int SH  = 4;
  localparam int NL  = 2;
  localparam int BPL = SW / NL;
  localparam longint MAXC = 16777215;
  localparam longint MINC = -16777216;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [2:0]          zoom;
  logic signed [W-1:0] x_offset, y_offset;
  logic                out_ready;
  logic                out_valid;
  logic [NL*W-1:0]     real_x;
  logic signed [W-1:0] imag_y;
  logic [PW-1:0]       pixel_x, pixel_y;
  logic                line_end, frame_end, busy;

  int n_assert = 0;
  int n_fail   = 0;
  int beats;

  pixel_map_stream #(
    .SCREEN_WIDTH (SW),
    .SCREEN_HEIGHT(SH),
    .N_LANES      (NL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .zoom     (zoom),
    .x_offset (x_offset),
    .y_offset (y_offset),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .real_x   (real_x),
    .imag_y   (imag_y),
    .pixel_x  (pixel_x),
    .pixel_y  (pixel_y),
    .line_end (line_end),
    .frame_end(frame_end),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] exp_coord(input longint v);
`ifdef PIXEL_MAP_SATURATE_EN
    if (v > MAXC) return MAXC;
    if (v < MINC) return MINC;
    return v;
`else
    logic signed [W-1:0] t;
    t = v[W-1:0];
    return t;
`endif
  endfunction

  function automatic logic signed [63:0] lane(input int k);
    logic signed [W-1:0] t;
    t = real_x[k*W +: W];
    return t;
  endfunction

  task automatic start_frame(input logic [2:0] z, input logic signed [W-1:0] xo, input logic signed [W-1:0] yo);
    @(negedge clk);
    zoom = z; x_offset = xo; y_offset = yo; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("setup1_valid", out_valid, 0);
    chk("setup1_busy", busy, 1);
    @(negedge clk);
    chk("setup2_valid", out_valid, 0);
    @(negedge clk);
    chk("run_valid", out_valid, 1);
  endtask

  task automatic check_beat(input int idx, input longint xs, input longint ys, input longint st);
    int px, py;
    px = (idx % BPL) * NL;
    py = idx / BPL;
    chk("pixel_x", pixel_x, px);
    chk("pixel_y", pixel_y, py);
    chk("lane0", lane(0), exp_coord(xs + px * st));
    chk("lane1", lane(1), exp_coord(xs + (px + 1) * st));
    chk("imag_y", imag_y, exp_coord(ys + py * st));
    chk("line_end", line_end, px == SW - NL);
    chk("frame_end", frame_end, (px == SW - NL) && (py == SH - 1));
  endtask

  // Streams from the current negedge until the frame drains; each cycle the
  // outputs must match the beat the model says is being presented.
  task automatic run_frame(input longint xs, input longint ys, input longint st,
                           input int first_idx, input int stall_at, input int disturb_at,
                           input int abort_at, output int n_beats);
    int idx, stall;
    idx = first_idx;
    stall = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (out_valid !== 1'b1) break;
      check_beat(idx, xs, ys, st);
      if (idx == abort_at) begin
        reset = 1'b0;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_frame_end", frame_end, 0);
        reset = 1'b1;
        n_beats = idx;
        return;
      end
      if (idx == stall_at && stall < 5) begin
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = 1'b1;
      end
      if (idx == disturb_at) begin
        zoom = 3'd5; x_offset = 25'sd123456; y_offset = -25'sd777; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      if (out_ready) idx++;
      @(negedge clk);
    end
    start = 1'b0;
    n_beats = idx;
    chk("drained_valid", out_valid, 0);
    chk("drained_busy", busy, 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; zoom = '0; x_offset = '0; y_offset = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_real_x", real_x, 0);
    chk("rst_imag_y", imag_y, 0);
    chk("rst_pixel_x", pixel_x, 0);
    chk("rst_line_end", line_end, 0);
    reset = 1'b1;

    // zoom 0, centred: step 4915, x_start -1572800, y_start -2*4915
    out_ready = 1'b1;
    start_frame(3'd0, 25'sd0, 25'sd0);
    chk("z0_lane0", lane(0), -1572800);
    chk("z0_lane1", lane(1), -1567885);
    chk("z0_imag", imag_y, -9830);
    run_frame(-1572800, -9830, 4915, 0, 100, 300, -1, beats);
    chk("z0_beats", beats, SW * SH / NL);

    // zoom 3: step 614, x_start -196480; abort with reset at beat 1000
    start_frame(3'd3, 25'sd0, 25'sd0);
    chk("z3_lane0", lane(0), -196480);
    chk("z3_lane1", lane(1), -195866);
    chk("z3_imag", imag_y, -1228);
    run_frame(-196480, -1228, 614, 0, -1, -1, 1000, beats);
    chk("abort_beats", beats, 1000);

    start_frame(3'd0, 25'sd0, 25'sd0);
    chk("restart_px", pixel_x, 0);
    chk("restart_py", pixel_y, 0);
    chk("restart_lane0", lane(0), -1572800);
    run_frame(-1572800, -9830, 4915, 0, -1, -1, -1, beats);
    chk("restart_beats", beats, SW * SH / NL);

    // overflow: x_start 15204415, pixel 639 = 18345100 before narrowing
    start_frame(3'd0, 25'sd16777215, 25'sd0);
    chk("ovf_lane0", lane(0), 15204415);
    out_ready = 1'b1;
    repeat (BPL - 1) @(negedge clk);
    chk("ovf_px", pixel_x, 638);
    chk("ovf_line_end", line_end, 1);
`ifdef PIXEL_MAP_SATURATE_EN
    chk("ovf_lane1", lane(1), 16777215);
`else
    chk("ovf_lane1", lane(1), -15209332);
`endif
    run_frame(15204415, -9830, 4915, BPL - 1, -1, -1, -1, beats);
    chk("ovf_beats", beats, SW * SH / NL);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
